// File: rtl/disparity_sweep_scheduler_pkg.sv
// Shared widths, scheduler state type and the disparity clamp helper used by the
// disparity sweep scheduler and its delay line.
package stereo_pkg;

    localparam int unsigned DISP_W       = 6;
    localparam int unsigned LANES        = 4;
    localparam int unsigned DISP_MAX_VAL = 63;
    localparam int unsigned PASS_W       = 4;
    localparam int unsigned RAW_W        = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFlush
    } sched_state_t;

    // Returns {disparity, mask_bit}; candidates past the search range saturate and
    // are masked off so compare_ws ignores them.
    function automatic logic [DISP_W:0] clamp_disp(input logic [RAW_W-1:0] raw);
        logic [DISP_W:0] res;
        if (raw > RAW_W'(DISP_MAX_VAL)) begin
            res = {DISP_W'(DISP_MAX_VAL), 1'b0};
        end else begin
            res = {raw[DISP_W-1:0], 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/disparity_sweep_scheduler_if.sv
// Column-start request plus the per-lane disparity and result-alignment outputs of
// the disparity sweep scheduler. master = requester/consumer side, slave = scheduler.
interface disparity_sweep_scheduler_if;
    import stereo_pkg::*;

    logic              read_start;
    logic [DISP_W-1:0] disp_offset;
    logic [DISP_W-1:0] disparity_1;
    logic [DISP_W-1:0] disparity_2;
    logic [DISP_W-1:0] disparity_3;
    logic [DISP_W-1:0] disparity_4;
    logic              issue;
    logic              valid;
    logic [LANES-1:0]  lane_mask;
    logic [PASS_W-1:0] pass_index;
    logic              clear_buffer;
    logic              busy;
    logic              overrun;

    modport master (
        output read_start, disp_offset,
        input  disparity_1, disparity_2, disparity_3, disparity_4,
        input  issue, valid, lane_mask, pass_index, clear_buffer, busy, overrun
    );

    modport slave (
        input  read_start, disp_offset,
        output disparity_1, disparity_2, disparity_3, disparity_4,
        output issue, valid, lane_mask, pass_index, clear_buffer, busy, overrun
    );

endinterface

// File: rtl/disparity_sweep_scheduler_delay_line.sv
// sched_delay_line: fixed-depth shift register that carries the {issue, mask, pass}
// tag alongside the SAD pipelines so it emerges as {valid, lane_mask, pass_index}.
module sched_delay_line #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Width-1:0] stage_q [Depth];

    // Advance the tag one stage per cycle; reset empties the whole line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[Depth-1];

endmodule

// File: rtl/disparity_sweep_scheduler.sv
// disparity_sweep_scheduler: on each accepted column start, issues MAX_DISP/4 passes
// of four candidate disparities, aligns valid/lane_mask/pass_index to the pipeline
// latency and pulses clear_buffer once the last result has been produced.
// Optional macro PENDING_START_EN: a start arriving mid-sweep is held in a one-deep
// pending slot and launched straight out of FLUSH instead of being dropped.
module disparity_sweep_scheduler #(
    parameter int unsigned MAX_DISP     = 64,
    parameter int unsigned PIPE_LATENCY = 8
) (
    input logic                        clock,
    input logic                        reset,
    disparity_sweep_scheduler_if.slave bus
);
    import stereo_pkg::*;

    localparam int unsigned       NUM_PASSES = MAX_DISP / 4;
    localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(NUM_PASSES - 1);
    localparam int unsigned       TAG_W      = 1 + LANES + PASS_W;

    sched_state_t      state_q;
    logic [DISP_W-1:0] base_q;
    logic [PASS_W-1:0] pass_q;
    logic              issue_q;
    logic              clear_q;
    logic              busy_q;
    logic              overrun_q;
    logic [DISP_W-1:0] disp_q [LANES];
    logic [LANES-1:0]  mask_q;
`ifdef PENDING_START_EN
    logic              pending_q;
    logic [DISP_W-1:0] shadow_q;
`endif

    logic              start_now;
    logic              issue_next;
    logic [DISP_W-1:0] issue_base;
    logic [PASS_W-1:0] issue_pass;
    logic [DISP_W:0]   lane_res [LANES];

    logic [TAG_W-1:0]  tag_in;
    logic [TAG_W-1:0]  tag_out;
    logic              dl_valid;
    logic [PASS_W-1:0] dl_pass;

    // Decide whether a pass is driven this edge and compute its four lane candidates.
    always_comb begin
        start_now = (state_q == StIdle) && bus.read_start;
`ifdef PENDING_START_EN
        start_now = start_now || ((state_q == StFlush) && (pending_q || bus.read_start));
`endif
        issue_next = start_now || ((state_q == StIssue) && (pass_q != LAST_PASS));

        if (state_q == StIssue) begin
            issue_base = base_q;
            issue_pass = pass_q + PASS_W'(1);
        end else begin
            issue_base = bus.disp_offset;
            issue_pass = '0;
`ifdef PENDING_START_EN
            // pending_q is only ever set outside IDLE, so this picks the shadow in FLUSH.
            if (pending_q) begin
                issue_base = shadow_q;
            end
`endif
        end

        for (int k = 0; k < int'(LANES); k++) begin
            lane_res[k] = clamp_disp(RAW_W'(issue_base) + RAW_W'({issue_pass, 2'b00}) +
                                     RAW_W'(k));
        end
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            pass_q    <= '0;
            issue_q   <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            mask_q    <= '0;
            for (int k = 0; k < int'(LANES); k++) begin
                disp_q[k] <= '0;
            end
`ifdef PENDING_START_EN
            pending_q <= 1'b0;
            shadow_q  <= '0;
`endif
        end else begin
            issue_q <= issue_next;
            clear_q <= 1'b0;

            // Disparities hold their last value between sweeps.
            if (issue_next) begin
                base_q <= issue_base;
                pass_q <= issue_pass;
                for (int k = 0; k < int'(LANES); k++) begin
                    disp_q[k] <= lane_res[k][DISP_W:1];
                    mask_q[k] <= lane_res[k][0];
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start_now) begin
                        state_q <= StIssue;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue: begin
                    if (!issue_next) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // The last pass leaving the delay line marks the sweep as complete.
                    if (dl_valid && (dl_pass == LAST_PASS)) begin
                        state_q <= StFlush;
                        clear_q <= 1'b1;
                    end
                end
                StFlush: begin
                    if (start_now) begin
                        state_q <= StIssue;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

`ifdef PENDING_START_EN
            if (state_q == StFlush) begin
                pending_q <= 1'b0;
            end
            if (bus.read_start && (state_q != StIdle)) begin
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else if (state_q != StFlush) begin
                    // A start seen in FLUSH is launched directly, so it needs no slot.
                    pending_q <= 1'b1;
                    shadow_q  <= bus.disp_offset;
                end
            end
`else
            if (bus.read_start && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
`endif
        end
    end

    // Only live passes carry a mask and index, so idle slots come out as all-zero.
    assign tag_in = {issue_q,
                     issue_q ? mask_q : {LANES{1'b0}},
                     issue_q ? pass_q : {PASS_W{1'b0}}};

    sched_delay_line #(
        .Depth (PIPE_LATENCY),
        .Width (TAG_W)
    ) u_delay_line (
        .clock (clock),
        .reset (reset),
        .din   (tag_in),
        .dout  (tag_out)
    );

    assign dl_valid = tag_out[TAG_W-1];
    assign dl_pass  = tag_out[PASS_W-1:0];

    assign bus.disparity_1  = disp_q[0];
    assign bus.disparity_2  = disp_q[1];
    assign bus.disparity_3  = disp_q[2];
    assign bus.disparity_4  = disp_q[3];
    assign bus.issue        = issue_q;
    assign bus.valid        = dl_valid;
    assign bus.lane_mask    = tag_out[PASS_W +: LANES];
    assign bus.pass_index   = dl_pass;
    assign bus.clear_buffer = clear_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_disparity_sweep_scheduler.sv
// Bench for disparity_sweep_scheduler: directed vector table, hand sequences for
// overrun/pending and asynchronous reset, then random starts against a sweep model.
`timescale 1ns/1ps
module tb_disparity_sweep_scheduler;
    import stereo_pkg::*;

    localparam int MAX_DISP = 16;
    localparam int L        = 8;
    localparam int N        = MAX_DISP / 4;
    localparam int SW       = N + L + 1;
`ifdef PENDING_START_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    disparity_sweep_scheduler_if bus_if();

    disparity_sweep_scheduler #(
        .MAX_DISP     (MAX_DISP),
        .PIPE_LATENCY (L)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sweep model: a sweep is (start edge, offset); outputs follow from the timing rules.
    int t = 0;
    bit m_active, m_pend, m_ovr;
    int m_s, m_off, m_pend_off;
    int m_d[4];
    int e_issue, e_valid, e_mask, e_pidx, e_clear, e_busy;

    typedef struct {
        int rs; int off;
        int issue; int valid; int mask; int pidx; int clear; int busy; int ovr;
        int d1; int d4;
    } vec_t;
    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    function automatic int sat(input int raw);
        return (raw > 63) ? 63 : raw;
    endfunction

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_ovr = 0;
        for (int k = 0; k < 4; k++) m_d[k] = 0;
        e_issue = 0; e_valid = 0; e_mask = 0; e_pidx = 0; e_clear = 0; e_busy = 0;
    endtask

    // Apply one edge's start decision, then derive the expected outputs after it.
    task automatic model_step(input bit rs, input int off);
        bit nonidle;
        int r;
        nonidle = m_active && (t <= m_s + SW);
        if (rs) begin
            if (!nonidle) begin
                m_s = t; m_off = off; m_active = 1;
            end else if (PEND && !m_pend) begin
                m_pend = 1; m_pend_off = off;
            end else begin
                m_ovr = 1;
            end
        end
        if (nonidle && (t == m_s + SW) && m_pend) begin
            m_s = t; m_off = m_pend_off; m_pend = 0;
        end
        r = m_active ? (t + 1 - m_s) : -1000;
        e_issue = (r >= 1 && r <= N);
        if (e_issue != 0) begin
            for (int k = 0; k < 4; k++) m_d[k] = sat(m_off + 4 * (r - 1) + k);
        end
        e_valid = (r >= 1 + L && r <= N + L);
        e_pidx  = (e_valid != 0) ? (r - 1 - L) : 0;
        e_mask  = 0;
        if (e_valid != 0) begin
            for (int k = 0; k < 4; k++)
                if (m_off + 4 * e_pidx + k <= 63) e_mask |= (1 << k);
        end
        e_clear = (r == N + L + 1);
        e_busy  = (r >= 1 && r <= N + L + 1);
        t++;
    endtask

    task automatic check_all();
        check("issue", bus_if.issue, e_issue);
        check("valid", bus_if.valid, e_valid);
        check("lane_mask", bus_if.lane_mask, e_mask);
        check("pass_index", bus_if.pass_index, e_pidx);
        check("clear_buffer", bus_if.clear_buffer, e_clear);
        check("busy", bus_if.busy, e_busy);
        check("overrun", bus_if.overrun, m_ovr);
        check("disparity_1", bus_if.disparity_1, m_d[0]);
        check("disparity_2", bus_if.disparity_2, m_d[1]);
        check("disparity_3", bus_if.disparity_3, m_d[2]);
        check("disparity_4", bus_if.disparity_4, m_d[3]);
    endtask

    // Called just after a negedge: drive inputs, take one edge, check at the next negedge.
    task automatic step(input bit rs, input int off);
        bus_if.read_start  = rs;
        bus_if.disp_offset = 6'(off);
        @(posedge clock);
        model_step(rs, off);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.read_start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bus_if.read_start  = 1'b0;
        bus_if.disp_offset = '0;
        vecs = '{
            '{1, 0,  1,0, 0,0, 0,1,0,  0, 3}, '{0, 0,  1,0, 0,0, 0,1,0,  4, 7},
            '{0, 0,  1,0, 0,0, 0,1,0,  8,11}, '{0, 0,  1,0, 0,0, 0,1,0, 12,15},
            '{0, 0,  0,0, 0,0, 0,1,0, 12,15}, '{0, 0,  0,0, 0,0, 0,1,0, 12,15},
            '{0, 0,  0,0, 0,0, 0,1,0, 12,15}, '{0, 0,  0,0, 0,0, 0,1,0, 12,15},
            '{0, 0,  0,1,15,0, 0,1,0, 12,15}, '{0, 0,  0,1,15,1, 0,1,0, 12,15},
            '{0, 0,  0,1,15,2, 0,1,0, 12,15}, '{0, 0,  0,1,15,3, 0,1,0, 12,15},
            '{0, 0,  0,0, 0,0, 1,1,0, 12,15}, '{0, 0,  0,0, 0,0, 0,0,0, 12,15},
            '{1,56,  1,0, 0,0, 0,1,0, 56,59}, '{0, 0,  1,0, 0,0, 0,1,0, 60,63},
            '{0, 0,  1,0, 0,0, 0,1,0, 63,63}, '{0, 0,  1,0, 0,0, 0,1,0, 63,63},
            '{0, 0,  0,0, 0,0, 0,1,0, 63,63}, '{0, 0,  0,0, 0,0, 0,1,0, 63,63},
            '{0, 0,  0,0, 0,0, 0,1,0, 63,63}, '{0, 0,  0,0, 0,0, 0,1,0, 63,63},
            '{0, 0,  0,1,15,0, 0,1,0, 63,63}, '{0, 0,  0,1,15,1, 0,1,0, 63,63},
            '{0, 0,  0,1, 0,2, 0,1,0, 63,63}, '{0, 0,  0,1, 0,3, 0,1,0, 63,63},
            '{0, 0,  0,0, 0,0, 1,1,0, 63,63}, '{0, 0,  0,0, 0,0, 0,0,0, 63,63}
        };

        // Reset state.
        repeat (2) @(negedge clock);
        model_reset();
        check_all();
        reset = 1'b0;

        // Offset 0 sweep, then an offset 56 sweep started the first cycle IDLE is visible.
        for (int i = 0; i < 28; i++) begin
            step(vecs[i].rs[0], vecs[i].off);
            check($sformatf("tbl%0d_issue", i), bus_if.issue, vecs[i].issue);
            check($sformatf("tbl%0d_valid", i), bus_if.valid, vecs[i].valid);
            check($sformatf("tbl%0d_mask", i), bus_if.lane_mask, vecs[i].mask);
            check($sformatf("tbl%0d_pidx", i), bus_if.pass_index, vecs[i].pidx);
            check($sformatf("tbl%0d_clear", i), bus_if.clear_buffer, vecs[i].clear);
            check($sformatf("tbl%0d_busy", i), bus_if.busy, vecs[i].busy);
            check($sformatf("tbl%0d_ovr", i), bus_if.overrun, vecs[i].ovr);
            check($sformatf("tbl%0d_d1", i), bus_if.disparity_1, vecs[i].d1);
            check($sformatf("tbl%0d_d4", i), bus_if.disparity_4, vecs[i].d4);
        end

        // Starts during a sweep: edge 5 (offset 4) and edge 6 (offset 9).
        do_reset();
        for (int e = 0; e < 30; e++) begin
            step(e == 0 || e == 5 || e == 6, (e == 5) ? 4 : ((e == 6) ? 9 : 0));
`ifdef PENDING_START_EN
            if (e == 13) begin
                check("pend_issue_c14", bus_if.issue, 1);
                check("pend_d1_c14", bus_if.disparity_1, 4);
                check("pend_d4_c14", bus_if.disparity_4, 7);
            end
`else
            if (e == 13) begin
                check("drop_issue_c14", bus_if.issue, 0);
                check("drop_busy_c14", bus_if.busy, 0);
            end
`endif
        end
        check("overrun_sticky", bus_if.overrun, 1);

        // Asynchronous reset mid-sweep, then a clean sweep.
        do_reset();
        for (int e = 0; e < 6; e++) step(e == 0, 20);
        #2 reset = 1'b1;
        #1;
        check("rst_issue", bus_if.issue, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_d1", bus_if.disparity_1, 0);
        check("rst_d4", bus_if.disparity_4, 0);
        check("rst_clear", bus_if.clear_buffer, 0);
        do_reset();
        for (int e = 0; e < 3 * SW; e++) step(e == 0, 33);

        // Random starts and offsets.
        do_reset();
        for (int e = 0; e < 3000; e++) begin
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, 63)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disparity_sweep_scheduler.md
Name: disparity_sweep_scheduler

Overview:
Sequences the four parallel SAD pipelines through the full disparity search for each pixel column. On each read_start it issues MAX_DISP/4 passes of four candidate disparities to the pipelines and the window-sum comparator. It aligns a result-valid strobe, lane mask and pass index to the pipeline latency, and then pulses clear_buffer so the output FIFO commits the winner. It sits in the clock_200 domain between buffer_to_pipeline and compare_ws/fifo_buffer.

Parameters:
MAX_DISP, 64, disparities searched per pixel; multiple of 4, range 4..64; NUM_PASSES = MAX_DISP/4
PIPE_LATENCY, 8, cycles from disparity issue to matching window sum at compare_ws output; >= 1

Ports:
clock  in  1  pipeline clock (clock_200)
reset  in  1  asynchronous, active-high reset
read_start  in  1  single-cycle column-start request, already synchronous to clock
disp_offset  in  6  base disparity; sampled only when a start is accepted
disparity_1..disparity_4  out  6 each  candidate disparity per lane
issue  out  1  high on each cycle a pass is driven to the pipelines
valid  out  1  compare_ws output corresponds to an issued pass
lane_mask  out  4  per-lane validity aligned with valid; bit k-1 is lane k
pass_index  out  4  pass number aligned with valid
clear_buffer  out  1  one-cycle commit pulse after the last valid
busy  out  1  sweep in progress
overrun  out  1  sticky; a start was dropped

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: disparity_*, issue, valid, lane_mask, pass_index, clear_buffer, busy, overrun. The delay line is cleared. Reset mid-sweep abandons the sweep and does not emit clear_buffer.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
  - IDLE -> ISSUE when read_start=1. On that edge, disp_offset is latched and pass 0 is loaded.
  - ISSUE: advances one pass per cycle. Goes to DRAIN after pass NUM_PASSES-1 is issued. If NUM_PASSES + PIPE_LATENCY makes the drain length 0, it goes directly to FLUSH.
  - DRAIN: holds until the final valid is output.
  - FLUSH: lasts one cycle with clear_buffer=1, then returns to IDLE.
- Timing, taking the start-sampling edge as cycle 0:
  - issue=1 on cycles 1..N (N = NUM_PASSES)
  - valid=1 on cycles 1+L..N+L (L = PIPE_LATENCY)
  - clear_buffer=1 on cycle N+L+1
  - busy=1 on cycles 1..N+L+1
  - IDLE is visible from cycle N+L+2
- Disparity arithmetic: lane k in pass p gets raw = disp_offset + 4p + (k-1), computed at 8 bits.
  - raw <= 63: disparity_k = raw, mask bit = 1.
  - raw > 63: disparity_k = 63 (saturated), mask bit = 0.
  - When issue=0, disparity_* hold their last value.
- Delay line: {issue, mask, pass} is delayed exactly L cycles to produce {valid, lane_mask, pass_index}. When valid=0, lane_mask=0 and pass_index=0.
- Start while state != IDLE (including FLUSH): the start is dropped and overrun is set to 1. overrun clears only on reset.
- A start asserted on the cycle IDLE is re-entered is accepted normally.

Optional Feature:
PENDING_START_EN
- Defined: a one-deep pending flag.
  - A start while busy sets pending and latches disp_offset into a shadow register.
  - FLUSH then goes directly to ISSUE using the shadow offset. The next issue is at cycle N+L+2, with no IDLE cycle.
  - A second start while pending is already set sets overrun.
- Undefined: every start while busy is dropped and sets overrun. No shadow register is built.

Decomposition:
- Shared package stereo_pkg:
  - DISP_W=6, LANES=4, DISP_MAX_VAL=63
  - sched_state_t enum (IDLE/ISSUE/DRAIN/FLUSH)
  - function clamp_disp returning {disparity, mask_bit}
- Sub-module sched_delay_line: parameterised-depth shift register of width 1+4+4 with async reset. It generates {valid, lane_mask, pass_index}.

Test Plan:
- MAX_DISP=16, L=8, offset=0, read_start at cycle 0 -> issue on cycles 1..4 with lanes 0-3/4-7/8-11/12-15; valid on cycles 9..12 with pass_index 0..3 and mask 1111; clear_buffer only on cycle 13; busy 1..13.
- offset=56, MAX_DISP=16 -> pass 0: 56-59, mask 1111; pass 1: 60-63, mask 1111; passes 2 and 3: all lanes 63, mask 0000 at valid.
- read_start at cycle 5 during a sweep (macro undefined) -> no second sweep, overrun=1 and stays 1; the first sweep's timing is unchanged.
- PENDING_START_EN defined, start at cycle 5 with offset=4 -> after clear_buffer at 13, issue resumes at cycle 14 with lanes 4-7; a third start at cycle 6 sets overrun.
- reset asserted at cycle 6 mid-sweep -> all outputs 0 immediately (asynchronous); no clear_buffer; a new start after release runs a clean sweep.
- Back-to-back: second start exactly when IDLE is visible (cycle 14) -> accepted, overrun stays 0.
